// File: rtl/legv8_program_loader.sv
// Framed byte-stream loader that fills the instruction memory (big-endian words)
// and holds the core in reset until a frame with a matching XOR checksum completes.
module legv8_program_loader #(
    parameter int          IM_BYTES = 64,
    parameter int          ADDR_W   = 6,
    parameter logic [7:0]  HDR_BYTE = 8'hA5
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              start,
    output logic              im_we,
    output logic [ADDR_W-1:0] im_addr,
    output logic [7:0]        im_wdata,
    output logic              core_hold,
    output logic              done,
    output logic              error,
    output logic [7:0]        words_loaded,
    output logic [2:0]        state_dbg
);

    // Handshake: a byte transfers on a rising edge where in_valid && in_ready.
    // in_ready depends on state only, never on in_valid.
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_COUNT = 3'd1,
        S_DATA  = 3'd2,
        S_CHECK = 3'd3,
        S_DONE  = 3'd4,
        S_ERROR = 3'd5
    } state_t;

    localparam logic [7:0]      MAX_WORDS = 8'(IM_BYTES / 4);
    localparam logic [ADDR_W:0] CNT_ONE   = 1;

    state_t            state;
    logic [ADDR_W-2:0] n_words;
    logic [ADDR_W:0]   byte_cnt;
    logic [7:0]        checksum;
    logic              accept;
    logic              last_byte;

    assign in_ready  = (state != S_DONE) && (state != S_ERROR);
    assign accept    = in_valid && in_ready;
    assign last_byte = ((byte_cnt + CNT_ONE) == {n_words, 2'b00});
    assign state_dbg = state;

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state        <= S_IDLE;
            n_words      <= '0;
            byte_cnt     <= '0;
            checksum     <= '0;
            im_we        <= 1'b0;
            im_addr      <= '0;
            im_wdata     <= '0;
            core_hold    <= 1'b1;
            done         <= 1'b0;
            error        <= 1'b0;
            words_loaded <= '0;
        end else begin
            im_we <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept && in_data == HDR_BYTE) state <= S_COUNT;
                end
                S_COUNT: begin
                    if (accept) begin
                        byte_cnt     <= '0;
                        checksum     <= '0;
                        words_loaded <= '0;
                        if (in_data == 8'd0) begin
                            state <= S_CHECK;
                        end else if (in_data > MAX_WORDS) begin
                            state <= S_ERROR;
                            error <= 1'b1;
                        end else begin
                            n_words <= in_data[ADDR_W-2:0];
                            state   <= S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    if (accept) begin
                        im_we    <= 1'b1;
                        im_addr  <= byte_cnt[ADDR_W-1:0];
                        im_wdata <= in_data;
                        checksum <= checksum ^ in_data;
                        byte_cnt <= byte_cnt + CNT_ONE;
                        if (byte_cnt[1:0] == 2'd3) words_loaded <= words_loaded + 8'd1;
                        if (last_byte) state <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (accept) begin
                        if (in_data == checksum) begin
                            state     <= S_DONE;
                            done      <= 1'b1;
                            core_hold <= 1'b0;
                        end else begin
                            state <= S_ERROR;
                            error <= 1'b1;
                        end
                    end
                end
                S_DONE, S_ERROR: begin
                    if (start) begin
                        state        <= S_IDLE;
                        done         <= 1'b0;
                        error        <= 1'b0;
                        words_loaded <= '0;
                        core_hold    <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_legv8_program_loader.sv
// Self-checking bench for legv8_program_loader: scoreboarded memory writes plus
// per-scenario status checks.
module tb_legv8_program_loader;

    logic       CLK = 1'b0;
    logic       RST;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic       start;
    logic       im_we;
    logic [5:0] im_addr;
    logic [7:0] im_wdata;
    logic       core_hold;
    logic       done;
    logic       error;
    logic [7:0] words_loaded;
    logic [2:0] state_dbg;

    int errors = 0;
    int checks = 0;
    logic [13:0] exp_q[$];
    logic [7:0]  pay[0:63];
    logic [7:0]  frame_a[0:7] = '{8'h8B, 8'h02, 8'h00, 8'h20, 8'hCB, 8'h03, 8'h00, 8'h41};

    localparam logic [2:0] ST_IDLE = 3'd0;

    legv8_program_loader dut (
        .CLK(CLK), .RST(RST), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .start(start), .im_we(im_we), .im_addr(im_addr), .im_wdata(im_wdata),
        .core_hold(core_hold), .done(done), .error(error), .words_loaded(words_loaded),
        .state_dbg(state_dbg)
    );

    always #5 CLK = ~CLK;

    // Write monitor: every strobe must match the oldest expected {addr, data}.
    always @(negedge CLK) begin
        if (im_we === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: got addr=%0d data=%h, none expected", im_addr, im_wdata);
            end else begin
                logic [13:0] e;
                e = exp_q.pop_front();
                if ({im_addr, im_wdata} !== e) begin
                    errors++;
                    $display("FAIL write: got addr=%0d data=%h want addr=%0d data=%h",
                             im_addr, im_wdata, e[13:8], e[7:0]);
                end
            end
        end
    end

    // Called at a negedge; the byte transfers at the next posedge if in_ready.
    task automatic send_byte(input logic [7:0] b, input bit payload, input logic [5:0] addr);
        in_data  = b;
        in_valid = 1'b1;
        if (payload && in_ready) exp_q.push_back({addr, b});
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic idle_cycles(input int n);
        in_valid = 1'b0;
        repeat (n) @(negedge CLK);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        start = 1'b0;
    endtask

    task automatic load_frame_a();
        for (int i = 0; i < 8; i++) pay[i] = frame_a[i];
    endtask

    // Sends header, count, 4n payload bytes from pay[], then good checksum ^ chk_mask.
    // A 3-cycle in_valid gap is inserted before payload index gap_at (if in range).
    task automatic send_frame(input int n, input logic [7:0] chk_mask, input int gap_at);
        logic [7:0] chk;
        chk = 8'h00;
        send_byte(8'hA5, 1'b0, 6'd0);
        send_byte(8'(n), 1'b0, 6'd0);
        for (int k = 0; k < 4 * n; k++) begin
            if (k == gap_at) idle_cycles(3);
            chk = chk ^ pay[k];
            send_byte(pay[k], 1'b1, 6'(k));
        end
        send_byte(chk ^ chk_mask, 1'b0, 6'd0);
        idle_cycles(1);
    endtask

    task automatic test_reset();
        RST = 1'b0;
        repeat (2) @(negedge CLK);
        checks++; if (im_we !== 1'b0) begin errors++; $display("FAIL reset_im_we: got %b want 0", im_we); end
        checks++; if (im_addr !== 6'd0) begin errors++; $display("FAIL reset_im_addr: got %0d want 0", im_addr); end
        checks++; if (im_wdata !== 8'd0) begin errors++; $display("FAIL reset_im_wdata: got %h want 00", im_wdata); end
        checks++; if (core_hold !== 1'b1) begin errors++; $display("FAIL reset_core_hold: got %b want 1", core_hold); end
        checks++; if (done !== 1'b0 || error !== 1'b0) begin errors++; $display("FAIL reset_done_error: got %b%b want 00", done, error); end
        checks++; if (words_loaded !== 8'd0) begin errors++; $display("FAIL reset_words: got %0d want 0", words_loaded); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        checks++; if (state_dbg !== ST_IDLE) begin errors++; $display("FAIL reset_state: got %0d want %0d", state_dbg, ST_IDLE); end
        RST = 1'b1;
        @(negedge CLK);
    endtask

    task automatic test_normal_load();
        load_frame_a();
        send_frame(2, 8'h00, -1);
        checks++; if (words_loaded !== 8'd2) begin errors++; $display("FAIL normal_words: got %0d want 2", words_loaded); end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL normal_done: got %b want 1", done); end
        checks++; if (core_hold !== 1'b0) begin errors++; $display("FAIL normal_core_hold: got %b want 0", core_hold); end
        checks++; if (error !== 1'b0) begin errors++; $display("FAIL normal_error: got %b want 0", error); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL normal_in_ready: got %b want 0", in_ready); end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL normal_writes_missing: got %0d pending want 0", exp_q.size()); end
        pulse_start();
        checks++; if (done !== 1'b0 || core_hold !== 1'b1) begin errors++; $display("FAIL normal_rearm: got done=%b hold=%b want 0 1", done, core_hold); end
    endtask

    task automatic test_bad_checksum();
        load_frame_a();
        send_frame(2, 8'h01, -1);
        checks++; if (error !== 1'b1) begin errors++; $display("FAIL bad_chk_error: got %b want 1", error); end
        checks++; if (core_hold !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL bad_chk_hold_done: got hold=%b done=%b want 1 0", core_hold, done); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bad_chk_in_ready: got %b want 0", in_ready); end
        for (int i = 0; i < 3; i++) send_byte(8'($urandom_range(0, 255)), 1'b1, 6'(i));
        checks++; if (error !== 1'b1) begin errors++; $display("FAIL bad_chk_sticky: got %b want 1", error); end
        // start together with a header byte: start wins, byte is not taken.
        in_data = 8'hA5; in_valid = 1'b1;
        pulse_start();
        in_valid = 1'b0;
        checks++; if (state_dbg !== ST_IDLE) begin errors++; $display("FAIL start_wins_state: got %0d want %0d", state_dbg, ST_IDLE); end
        checks++; if (error !== 1'b0 || words_loaded !== 8'd0) begin errors++; $display("FAIL start_clears: got err=%b words=%0d want 0 0", error, words_loaded); end
        @(negedge CLK);
    endtask

    task automatic test_oversize();
        send_byte(8'hA5, 1'b0, 6'd0);
        send_byte(8'h11, 1'b0, 6'd0);
        checks++; if (error !== 1'b1) begin errors++; $display("FAIL oversize_error: got %b want 1", error); end
        checks++; if (core_hold !== 1'b1) begin errors++; $display("FAIL oversize_hold: got %b want 1", core_hold); end
        for (int i = 0; i < 4; i++) send_byte(8'($urandom_range(0, 255)), 1'b1, 6'(i));
        idle_cycles(1);
        pulse_start();
    endtask

    task automatic test_junk_gaps();
        send_byte(8'h00, 1'b0, 6'd0);
        send_byte(8'hFF, 1'b0, 6'd0);
        send_byte(8'h3C, 1'b0, 6'd0);
        idle_cycles(1);
        checks++; if (state_dbg !== ST_IDLE || error !== 1'b0) begin errors++; $display("FAIL junk_dropped: got state=%0d err=%b want %0d 0", state_dbg, error, ST_IDLE); end
        load_frame_a();
        send_frame(2, 8'h00, 3);
        checks++; if (done !== 1'b1 || error !== 1'b0) begin errors++; $display("FAIL gap_done: got done=%b err=%b want 1 0", done, error); end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL gap_writes_missing: got %0d pending want 0", exp_q.size()); end
        pulse_start();
    endtask

    task automatic test_empty_rearm();
        send_frame(0, 8'h00, -1);
        checks++; if (done !== 1'b1 || words_loaded !== 8'd0) begin errors++; $display("FAIL empty_done: got done=%b words=%0d want 1 0", done, words_loaded); end
        pulse_start();
        checks++; if (done !== 1'b0 || core_hold !== 1'b1 || in_ready !== 1'b1) begin errors++; $display("FAIL empty_rearm: got done=%b hold=%b rdy=%b want 0 1 1", done, core_hold, in_ready); end
        for (int i = 0; i < 12; i++) pay[i] = 8'($urandom_range(0, 255));
        send_frame(3, 8'h00, -1);
        checks++; if (done !== 1'b1 || words_loaded !== 8'd3) begin errors++; $display("FAIL second_frame: got done=%b words=%0d want 1 3", done, words_loaded); end
        pulse_start();
    endtask

    task automatic test_mid_reset();
        load_frame_a();
        send_byte(8'hA5, 1'b0, 6'd0);
        send_byte(8'h02, 1'b0, 6'd0);
        for (int k = 0; k < 5; k++) send_byte(pay[k], 1'b1, 6'(k));
        in_valid = 1'b0;
        RST = 1'b0;
        @(posedge CLK);
        @(negedge CLK);
        checks++; if (state_dbg !== ST_IDLE || im_we !== 1'b0) begin errors++; $display("FAIL midrst_state: got state=%0d we=%b want %0d 0", state_dbg, im_we, ST_IDLE); end
        checks++; if (im_addr !== 6'd0 || im_wdata !== 8'd0) begin errors++; $display("FAIL midrst_addr_data: got %0d %h want 0 00", im_addr, im_wdata); end
        checks++; if (words_loaded !== 8'd0 || core_hold !== 1'b1 || done !== 1'b0 || error !== 1'b0) begin errors++; $display("FAIL midrst_status: got words=%0d hold=%b done=%b err=%b want 0 1 0 0", words_loaded, core_hold, done, error); end
        RST = 1'b1;
        @(negedge CLK);
        send_frame(2, 8'h00, -1);
        checks++; if (done !== 1'b1 || core_hold !== 1'b0) begin errors++; $display("FAIL midrst_reload: got done=%b hold=%b want 1 0", done, core_hold); end
    endtask

    initial begin
        RST = 1'b0; in_data = 8'h00; in_valid = 1'b0; start = 1'b0;
        @(negedge CLK);
        test_reset();
        test_normal_load();
        test_bad_checksum();
        test_oversize();
        test_junk_gaps();
        test_empty_rearm();
        test_mid_reset();
        idle_cycles(2);
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL final_queue: got %0d pending want 0", exp_q.size()); end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
